// File: rtl/cpu_pkg.sv
// Shared types for the accumulator CPU: memory handshake, opcodes, FSM states.
package cpu_pkg;

    localparam int unsigned MEMSIZE = 16;
    localparam int unsigned REGSIZE = 8;

    typedef logic [REGSIZE-1:0] DEFAULT_TYPE;

    // Command word driven into memory_unit each cycle
    typedef enum logic [3:0] {
        MEMORY_STAY  = 4'd0,
        MEMORY_READ  = 4'd1,
        MEMORY_WRITE = 4'd2
    } MEMORY_FLAG;

    // Upper nibble of an instruction; codes 8..E are undefined and run as NOP
    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_JMP = 4'h5,
        OP_JZ  = 4'h6,
        OP_LDI = 4'h7,
        OP_HLT = 4'hF
    } OPCODE;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEMRD,
        S_MEMWR,
        S_HALT
    } CPU_STATE;

endpackage

// File: rtl/cpu_control_unit_alu.sv
// Combinational ALU for memory-operand instructions (LDA/ADD/SUB).
module alu_unit
    import cpu_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  OPCODE        op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] result_o,
    output logic         carry_o,
    output logic         zero_o
);

    logic [W:0] sum;
    logic [W:0] diff;

    // Carry is the adder carry-out for ADD and the borrow for SUB; LDA passes b through
    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        diff     = {1'b0, a_i} - {1'b0, b_i};
        result_o = b_i;
        carry_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o = sum[W-1:0];
                carry_o  = sum[W];
            end
            OP_SUB: begin
                result_o = diff[W-1:0];
                carry_o  = diff[W];
            end
            default: ;
        endcase
        zero_o = (result_o == '0);
    end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle accumulator CPU sequencer; sole master of memory_unit.
module cpu_control_unit #(
    parameter int unsigned MEMSIZE = cpu_pkg::MEMSIZE,
    parameter int unsigned REGSIZE = cpu_pkg::REGSIZE
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                step_enable,
    output cpu_pkg::MEMORY_FLAG rw_flag,
    output logic [REGSIZE-1:0]  address,
    output logic [REGSIZE-1:0]  write_value,
    input  logic [REGSIZE-1:0]  read_value,
    output logic                halted,
    output logic [REGSIZE-1:0]  pc_out,
    output logic [REGSIZE-1:0]  acc_out
);
    import cpu_pkg::*;

    CPU_STATE            state_q;
    logic [REGSIZE-1:0]  pc_q;
    logic [REGSIZE-1:0]  acc_q;
    logic [REGSIZE-1:0]  ir_q;
    logic                zf_q;
    logic                cf_q;

    OPCODE               opcode;
    logic [REGSIZE-1:0]  operand_ext;
    logic [REGSIZE-1:0]  operand_addr;
    logic [REGSIZE-1:0]  alu_result;
    logic                alu_carry;
    logic                alu_zero;

    function automatic logic [REGSIZE-1:0] wrap_addr(input logic [REGSIZE-1:0] a);
        return REGSIZE'(32'(a) % MEMSIZE);
    endfunction

    // Split the latched instruction into opcode and zero-extended operand
    always_comb begin
        opcode       = OPCODE'(ir_q[REGSIZE-1 -: 4]);
        operand_ext  = {{(REGSIZE-4){1'b0}}, ir_q[3:0]};
        operand_addr = wrap_addr(operand_ext);
    end

    alu_unit #(.W(REGSIZE)) u_alu (
        .op_i     (opcode),
        .a_i      (acc_q),
        .b_i      (read_value),
        .result_o (alu_result),
        .carry_o  (alu_carry),
        .zero_o   (alu_zero)
    );

    // Sequencer and architectural registers; step_enable=0 freezes everything
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            acc_q   <= '0;
            ir_q    <= '0;
            zf_q    <= 1'b0;
            cf_q    <= 1'b0;
        end else if (step_enable) begin
            case (state_q)
                S_FETCH: begin
                    ir_q    <= read_value;
                    pc_q    <= wrap_addr(pc_q + 1'b1);
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: state_q <= S_MEMRD;
                        OP_STA: state_q <= S_MEMWR;
                        OP_JMP: begin
                            pc_q    <= operand_addr;
                            state_q <= S_FETCH;
                        end
                        OP_JZ: begin
                            if (zf_q) pc_q <= operand_addr;
                            state_q <= S_FETCH;
                        end
                        OP_LDI: begin
                            acc_q   <= operand_ext;
                            zf_q    <= (operand_ext == '0);
                            state_q <= S_FETCH;
                        end
                        OP_HLT: state_q <= S_HALT;
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEMRD: begin
                    acc_q <= alu_result;
                    zf_q  <= alu_zero;
                    if (opcode != OP_LDA) cf_q <= alu_carry;
                    state_q <= S_FETCH;
                end
                S_MEMWR: state_q <= S_FETCH;
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Memory command decode; RESET forces an idle bus so an aborted store never issues
    always_comb begin
        rw_flag     = MEMORY_STAY;
        address     = '0;
        write_value = '0;
        halted      = 1'b0;
        if (!RESET) begin
            write_value = acc_q;
            halted      = (state_q == S_HALT);
            address     = pc_q;
            case (state_q)
                S_FETCH: if (step_enable) rw_flag = MEMORY_READ;
                S_MEMRD: begin
                    address = operand_addr;
                    if (step_enable) rw_flag = MEMORY_READ;
                end
                S_MEMWR: begin
                    address = operand_addr;
                    if (step_enable) rw_flag = MEMORY_WRITE;
                end
                default: ;
            endcase
        end
    end

    assign pc_out  = pc_q;
    assign acc_out = acc_q;

endmodule
